// File: rtl/velocity_cell_streamer.sv
// velocity_cell_streamer: reads the particle count at address 0, then streams addresses 1..N
// through a 2-entry output buffer. Optional count clamp and count_err flag: VEL_COUNT_CLAMP_EN.
module velocity_cell_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    // out_*: a beat transfers in any cycle with out_valid & out_ready; while out_valid is
    // high and out_ready low, out_data/out_index/out_last hold and out_valid stays high.
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
`ifdef VEL_COUNT_CLAMP_EN
    output logic                  count_err,
`endif
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_WAIT_CNT = 3'd2,
        S_STREAM   = 3'd3,
        S_DRAIN    = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rden;
    logic                  r_ret_vld;
    logic [ADDR_WIDTH-1:0] r_ret_idx;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [ADDR_WIDTH-1:0] r_buf_idx  [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    logic                  w_occ_nz;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_head_idx;
    logic                  w_pop;
    logic                  w_buf_push;
    logic                  w_buf_pop;
    logic [1:0]            w_occ_nxt;
    logic [2:0]            w_held;
    logic                  w_credit;
    logic                  w_last_issue;
    logic                  w_drained;
    logic [ADDR_WIDTH-1:0] w_count_raw;
    logic [ADDR_WIDTH-1:0] w_count;

    assign w_count_raw = ram_q[ADDR_WIDTH-1:0];

`ifdef VEL_COUNT_CLAMP_EN
    localparam logic [ADDR_WIDTH-1:0] L_MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    logic w_count_ovf;
    logic r_count_err;
    assign w_count_ovf = (w_count_raw > L_MAX_COUNT);
    assign w_count     = w_count_ovf ? L_MAX_COUNT : w_count_raw;
    assign count_err   = r_count_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_count_err <= 1'b0;
        end else if (r_state == S_WAIT_CNT && w_count_ovf) begin
            r_count_err <= 1'b1;
        end
    end
`else
    assign w_count = w_count_raw;
`endif

    // A word returning from memory bypasses the buffer when the buffer is empty,
    // which is what gives the 4-cycle start-to-first-beat latency.
    assign w_occ_nz    = (r_occ != 2'd0);
    assign w_valid     = w_occ_nz | r_ret_vld;
    assign w_head_data = w_occ_nz ? r_buf_data[r_rd_ptr] : ram_q;
    assign w_head_idx  = w_occ_nz ? r_buf_idx[r_rd_ptr] : r_ret_idx;
    assign w_pop       = w_valid & out_ready;
    assign w_buf_push  = r_ret_vld & ~(~w_occ_nz & w_pop);
    assign w_buf_pop   = w_pop & w_occ_nz;
    assign w_occ_nxt   = r_occ + 2'(w_buf_push) - 2'(w_buf_pop);

    // Held words: buffered, returning this cycle, and issued this cycle.
    assign w_held       = 3'(r_occ) + 3'(r_ret_vld) + 3'(r_rden);
    assign w_credit     = (w_held - 3'(w_pop)) < 3'd2;
    assign w_last_issue = r_rden & (r_addr == r_count);
    assign w_drained    = (w_occ_nxt == 2'd0) & ~r_rden;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_RD_CNT;
            S_RD_CNT:   w_state_nxt = S_WAIT_CNT;
            S_WAIT_CNT: w_state_nxt = (w_count == '0) ? S_FIN : S_STREAM;
            S_STREAM:   if (w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN:    if (w_drained) w_state_nxt = S_FIN;
            S_FIN:      w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = r_state;
        case (r_state)
            S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN: busy = 1'b1;
            S_FIN:   done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // r_addr is the address presented this cycle; it advances only once that read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_rden    <= 1'b0;
            r_count   <= '0;
            r_ret_vld <= 1'b0;
            r_ret_idx <= '0;
        end else begin
            r_ret_vld <= r_rden && (r_state == S_STREAM);
            r_ret_idx <= r_addr;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rden <= 1'b1;
                        r_addr <= '0;
                    end
                end
                S_WAIT_CNT: begin
                    r_count <= w_count;
                    r_addr  <= ADDR_WIDTH'(1);
                    r_rden  <= (w_count != '0);
                end
                S_STREAM: begin
                    if (r_rden) r_addr <= r_addr + ADDR_WIDTH'(1);
                    r_rden <= ~w_last_issue & w_credit;
                end
                default: r_rden <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_idx[i]  <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_buf_push) begin
                r_buf_data[r_wr_ptr] <= ram_q;
                r_buf_idx[r_wr_ptr]  <= r_ret_idx;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_buf_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= w_occ_nxt;
        end
    end

    assign ram_address = r_addr;
    assign ram_rden    = r_rden;
    assign ram_wren    = 1'b0;
    assign out_valid   = w_valid;
    assign out_data    = w_valid ? w_head_data : '0;
    assign out_index   = w_valid ? w_head_idx : '0;
    assign out_last    = w_valid && (w_head_idx == r_count);

endmodule

// File: doc/velocity_cell_streamer.md
# velocity_cell_streamer

Read sequencer for one per-cell velocity memory. On `start` it reads the particle count stored at address 0, then streams velocities from addresses 1..N to the downstream velocity cache / motion-update stage over a valid/ready interface. It hides the memory's 1-cycle read latency with a 2-entry output buffer, so it sustains one particle per cycle under continuous `out_ready`.

## Interface
- `DATA_WIDTH`, 96, velocity word width, `{vz, vy, vx}`, 32 bits each.
- `PARTICLE_NUM`, 220, memory depth in words, including the count word at address 0.
- `ADDR_WIDTH`, 8, memory address width.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a cell readout. Ignored while `busy`.
- `ram_address` out ADDR_WIDTH: velocity memory address. Registered.
- `ram_rden` out 1: velocity memory read enable. Registered.
- `ram_wren` out 1: tied to 0. Writes are muxed in outside this block.
- `ram_q` in DATA_WIDTH: memory read data, valid 1 cycle after `ram_rden`.
- `out_valid` out 1: streamed word is valid.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out DATA_WIDTH: velocity word `{vz, vy, vx}`.
- `out_index` out ADDR_WIDTH: particle index of `out_data`, range 1..N.
- `out_last` out 1: qualifies the final particle of the cell.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `count_err` out 1: sticky count-overflow flag. Present only with `VEL_COUNT_CLAMP_EN`.

## Operation
- FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN.
- IDLE: on `start`, go to RD_CNT.
- RD_CNT: drive `ram_rden`=1 with `ram_address`=0 for one cycle, then go to WAIT_CNT.
- WAIT_CNT: latch N = `ram_q[ADDR_WIDTH-1:0]`; set the next read address to 1.
  - If N=0, go to FIN with no beats.
  - Otherwise go to STREAM.
- STREAM: issue one read per cycle while credit allows.
  - Credit rule: `occupancy + inflight - pop < 2`, where `pop` = `out_valid & out_ready` in the same cycle.
  - Each return writes the buffer tagged with its index.
  - After the read of address N is issued, go to DRAIN.
- DRAIN: no reads. Go to FIN once the buffer is empty and nothing is in flight.
- FIN: pulse `done` for one cycle, drop `busy`, return to IDLE.
- Output buffer: 2-entry FIFO, head drives `out_*`.
  - `out_data`, `out_index` and `out_last` stay stable while `out_valid & !out_ready`.
  - `out_last` = (`out_index` == N).
- Index arithmetic: ADDR_WIDTH-bit unsigned, incremented by 1 per issued read.
- `start` while busy: ignored, no state change.
- `rst_n` low, including mid-stream: immediate return to IDLE; buffer and in-flight tracking are flushed.
- Reset values: `ram_address`=0, `ram_rden`=0, `ram_wren`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0, `count_err`=0.

## Timing
- `start` sampled at edge 0.
- Cycle 1: `ram_rden`=1, address 0, `busy`=1.
- Cycle 2: count available on `ram_q`; latched at the end of cycle 2.
- Cycle 3: read of address 1 issued.
- Cycle 4: first `out_valid`. Start-to-first-beat latency is 4 cycles.
- With `out_ready` held high: one beat per cycle, no bubbles. Last beat at cycle 3+N; `done` at cycle 4+N or later.
- Back-pressure: the credit rule never overflows the 2-entry buffer.
  - At most 2 words are held, counting buffered and in-flight.
  - Reads stall in the cycle the buffer would otherwise overflow.
  - Reads resume the cycle after a pop.
- `done` follows the handshake of the `out_last` beat by exactly 1 cycle. For N=0, `done` is at cycle 3.

## Configuration
- `VEL_COUNT_CLAMP_EN` defined:
  - If N > PARTICLE_NUM-1, N is replaced by PARTICLE_NUM-1.
  - `count_err` is set; it clears only on reset or the next `start`.
- `VEL_COUNT_CLAMP_EN` undefined:
  - The `count_err` port is absent.
  - The raw N is used unchecked; addresses wrap modulo 2^ADDR_WIDTH.

## Test plan
- N=5, `out_ready`=1, address k holding k·0x010101 -> 5 beats on cycles 4..8, indices 1..5, `out_last` on index 5, `done` at cycle 9.
- N=0 -> no `out_valid`, `done` at cycle 3, `busy` high for cycles 1..2.
- N=8 with `out_ready` toggling 1,0,0,1 -> all 8 words delivered in order, no loss or duplication, data held stable during stalls, at most 2 outstanding.
- `start` re-pulsed at cycle 5 during N=6 -> ignored; exactly 6 beats and a single `done`.
- `rst_n` asserted at cycle 6 of N=10, released 2 cycles later, then `start` -> all outputs at reset values; the fresh run streams indices 1..10.
- `VEL_COUNT_CLAMP_EN` with count word 250 and `PARTICLE_NUM`=220 -> `count_err`=1, exactly 219 beats, `out_last` at index 219.
